counter_updown_reg: RTL and testbench
=====================================

Name: counter_updown_reg

Overview:
- Registered up/down counter stage built around the existing incrementer-decrementer (IncDecC).
- Owns the state register: drives the incrementer-decrementer operand from its current count and captures the result and carry/borrow on each clock edge.
- Adds load, enable, wrap/saturate policy and registered status flags.
- Intended as the standard counter primitive for address generators and event counters in the arithmetic library.

Parameters:
- width, 8, counter word width (≥2).
- speed, 2, passed unchanged to the internal incrementer-decrementer (0 serial, 1 Brent-Kung, 2 Sklansky).
- SAT, 0, overflow policy: 0 = wrap-around, 1 = saturate at the all-ones / zero bounds.
- RSTVAL, 0, count value loaded on reset (width bits).

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous active-high reset.
- LD  input  1  load D into the counter (highest priority after RST).
- D  input  width  load value.
- EN  input  1  count enable; one step per enabled cycle.
- DEC  input  1  direction while counting: 0 = +1, 1 = −1.
- Q  output  width  current count (registered).
- OVF  output  1  registered one-cycle pulse: the previous step carried (inc at all-ones) or borrowed (dec at zero).
- ZERO  output  1  registered: Q == 0.
- FULL  output  1  registered: Q == all ones.

Behaviour:
- Clock and reset: single clock CLK. RST is synchronous, active-high, sampled on the rising edge.
- Reset values: Q = RSTVAL, OVF = 0, ZERO = (RSTVAL == 0), FULL = (RSTVAL == 2^width−1).
- Datapath:
  - Incrementer-decrementer inputs are A = Q, CI = 1, DEC = DEC.
  - Its Z output is the next count (nxt).
  - Its CO output is the carry/borrow (cb): 1 exactly when (DEC=0 and Q = all ones) or (DEC=1 and Q = 0).
- Priority per rising edge: RST > LD > EN > hold.
  - LD=1: Q ← D, OVF ← 0. EN and DEC are ignored.
  - EN=1, SAT=0: Q ← nxt (wraps modulo 2^width), OVF ← cb.
  - EN=1, SAT=1: if cb, Q holds; otherwise Q ← nxt. OVF ← cb in both cases, so OVF still flags each attempted step past a bound.
  - EN=0: Q holds, OVF ← 0.
- Flags:
  - ZERO and FULL are computed from the value being written to Q and registered with it, so they are always consistent with Q in the same cycle.
  - No combinational path from any input to Q, OVF, ZERO or FULL.
- Timing:
  - Latency is one cycle from EN/LD sampled to Q updated.
  - Sustained throughput is one step per cycle.
  - OVF is high for exactly one cycle per overflowing step. Back-to-back saturated attempts keep OVF high continuously.
- Direction change: DEC may toggle every cycle. Each step uses the DEC value sampled at that edge.
- Reset mid-operation: RST overrides LD/EN in the same cycle and clears a pending OVF. Counting resumes from RSTVAL on the first edge after RST deasserts.
- X-safety: when EN=0 and LD=0, the D and DEC values must not affect state.
- Implementation: instantiate the existing incrementer-decrementer with (width, speed). Do not re-implement the prefix logic.

Test Plan:
- width=4, RSTVAL=0. Reset, then EN=1 DEC=0 for 16 cycles. Required: Q goes 1..15 then 0. OVF pulses exactly on the 15→0 step. FULL is high while Q=15. ZERO is high before the first step and again after the wrap.
- width=4, SAT=1. LD D=14, then EN=1 DEC=0 for 4 cycles. Required: Q = 14, 15, 15, 15, 15. OVF is low on the 14→15 step and high on each of the following 3 cycles.
- width=4, SAT=0. LD D=1, then EN=1 DEC=1 for 3 cycles. Required: Q = 1, 0, 15, 14. OVF is high only on the 0→15 step. ZERO is high while Q=0.
- LD=1 D=9 with EN=1 DEC=0 in the same cycle, starting from Q=15. Required: Q=9 next cycle and OVF=0, showing load priority with no overflow reported.
- Counting with Q=5 and EN=1. Assert RST for one cycle with LD=1 D=3. Required: Q=RSTVAL=0 and OVF=0 next cycle, then Q=1 on the first enabled cycle after RST deasserts.
- Random regression at width=8 for each speed ∈ {0,1,2} and SAT ∈ {0,1}, 10k cycles of random RST/LD/EN/DEC. Compare Q, OVF, ZERO and FULL against a behavioural model cycle by cycle. Required: zero mismatches.

Source files
------------

// File: rtl/counter_updown_reg.sv
// Registered up/down counter primitive with load, enable, wrap/saturate policy
// and registered status flags, built around the IncDecC incrementer-decrementer.

// Incrementer-decrementer: Z = A + CI (DEC=0) or A - CI (DEC=1).
// CO is the carry out of the top bit on increment, or the borrow on decrement.
// Decrement reuses the increment carry chain on the complemented operand:
// bit i toggles exactly when every lower bit of A (or ~A) is one.
module IncDecC #(
    parameter int width = 8,
    parameter int speed = 2
) (
    input  logic [width-1:0] A,
    input  logic             CI,
    input  logic             DEC,
    output logic [width-1:0] Z,
    output logic             CO
);
    localparam int L = (width > 1) ? $clog2(width) : 1;

    logic [width-1:0] p;   // per-bit propagate
    logic [width-1:0] g;   // g[i] = AND of p[0..i]
    logic [width-1:0] c;   // carry into bit i

    assign p = DEC ? ~A : A;

    generate
        if (speed == 0) begin : g_serial
            // Ripple prefix-AND: one gate per bit, linear depth.
            always_comb begin
                logic [width-1:0] lvl;
                lvl    = p;
                for (int i = 1; i < width; i++) begin
                    lvl[i] = lvl[i-1] & p[i];
                end
                g = lvl;
            end
        end else if (speed == 1) begin : g_brent_kung
            // Brent-Kung: up-sweep builds power-of-two blocks, down-sweep fills the gaps.
            always_comb begin
                logic [width-1:0] lvl;
                logic [width-1:0] prev;
                lvl  = p;
                prev = p;
                for (int l = 0; l < L; l++) begin
                    prev = lvl;
                    for (int i = 0; i < width; i++) begin
                        if (((i + 1) % (2 << l)) == 0) begin
                            lvl[i] = prev[i] & prev[i - (1 << l)];
                        end
                    end
                end
                for (int l = L - 2; l >= 0; l--) begin
                    prev = lvl;
                    for (int i = 0; i < width; i++) begin
                        if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
                            lvl[i] = prev[i] & prev[i - (1 << l)];
                        end
                    end
                end
                g = lvl;
            end
        end else begin : g_sklansky
            // Sklansky: at level l every bit with index bit l set absorbs the
            // complete prefix of the block just below it (log depth, high fanout).
            always_comb begin
                logic [width-1:0] lvl;
                logic [width-1:0] prev;
                lvl  = p;
                prev = p;
                for (int l = 0; l < L; l++) begin
                    prev = lvl;
                    for (int i = 0; i < width; i++) begin
                        if (((i >> l) & 1) == 1) begin
                            lvl[i] = prev[i] & prev[((i >> l) << l) - 1];
                        end
                    end
                end
                g = lvl;
            end
        end
    endgenerate

    assign c[0] = CI;

    genvar gi;
    generate
        for (gi = 1; gi < width; gi++) begin : g_carry
            assign c[gi] = CI & g[gi-1];
        end
    endgenerate

    assign Z  = A ^ c;
    assign CO = CI & g[width-1];
endmodule

// Counter stage: owns the count register and feeds it back through IncDecC.
module counter_updown_reg #(
    parameter int               width  = 8,
    parameter int               speed  = 2,
    parameter bit               SAT    = 1'b0,
    parameter logic [width-1:0] RSTVAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LD,
    input  logic [width-1:0] D,
    input  logic             EN,
    input  logic             DEC,
    output logic [width-1:0] Q,
    output logic             OVF,
    output logic             ZERO,
    output logic             FULL
);
    logic [width-1:0] q_reg;
    logic [width-1:0] q_next;
    logic [width-1:0] nxt;
    logic             cb;
    logic             ovf_reg;
    logic             ovf_next;
    logic             zero_reg;
    logic             full_reg;

    IncDecC #(
        .width (width),
        .speed (speed)
    ) u_incdec (
        .A   (q_reg),
        .CI  (1'b1),
        .DEC (DEC),
        .Z   (nxt),
        .CO  (cb)
    );

    // Next count: load beats count beats hold; saturation blocks the step but still flags it.
    always_comb begin
        q_next   = q_reg;
        ovf_next = 1'b0;
        if (LD) begin
            q_next = D;
        end else if (EN) begin
            ovf_next = cb;
            if (!(SAT && cb)) begin
                q_next = nxt;
            end
        end
    end

    // State register; flags derive from the value being written so they track Q exactly.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_reg    <= RSTVAL;
            ovf_reg  <= 1'b0;
            zero_reg <= (RSTVAL == '0);
            full_reg <= (RSTVAL == '1);
        end else begin
            q_reg    <= q_next;
            ovf_reg  <= ovf_next;
            zero_reg <= (q_next == '0);
            full_reg <= (q_next == '1);
        end
    end

    assign Q    = q_reg;
    assign OVF  = ovf_reg;
    assign ZERO = zero_reg;
    assign FULL = full_reg;
endmodule

// File: tb/tb_counter_updown_reg.sv
// Self-checking bench: directed width-4 scenarios plus a randomized width-8
// regression over every speed/SAT combination against an arithmetic model.
module tb_counter_updown_reg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- width-4 instances (wrap and saturate) ----------------
    logic       rst4 = 1'b0, ld4 = 1'b0, en4 = 1'b0, dec4 = 1'b0;
    logic [3:0] d4 = '0;
    logic [3:0] qw, qs;
    logic       ovfw, zw, fw, ovfs, zs, fs;

    counter_updown_reg #(.width(4), .speed(2), .SAT(1'b0), .RSTVAL(4'd0)) u_w4 (
        .CLK(clk), .RST(rst4), .LD(ld4), .D(d4), .EN(en4), .DEC(dec4),
        .Q(qw), .OVF(ovfw), .ZERO(zw), .FULL(fw));

    counter_updown_reg #(.width(4), .speed(1), .SAT(1'b1), .RSTVAL(4'd0)) u_s4 (
        .CLK(clk), .RST(rst4), .LD(ld4), .D(d4), .EN(en4), .DEC(dec4),
        .Q(qs), .OVF(ovfs), .ZERO(zs), .FULL(fs));

    task automatic apply4(input logic r, input logic l, input logic [3:0] d,
                          input logic e, input logic dn);
        @(negedge clk);
        rst4 = r; ld4 = l; d4 = d; en4 = e; dec4 = dn;
        @(posedge clk);
        #1;
        $display("tx rst=%0d ld=%0d d=%0d en=%0d dec=%0d -> wrap q=%0d ovf=%0d | sat q=%0d ovf=%0d",
                 r, l, d, e, dn, qw, ovfw, qs, ovfs);
    endtask

    // ---------------- width-8 instances: speed 0..2 x SAT 0/1 ----------------
    logic            rst8 = 1'b0, ld8 = 1'b0, en8 = 1'b0, dec8 = 1'b0;
    logic [7:0]      d8 = '0;
    logic [5:0][7:0] q8;
    logic [5:0]      ovf8, z8, f8;

    function automatic int rv(input int k);
        return (k == 5) ? 255 : k * 40;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_dut8
            counter_updown_reg #(
                .width(8), .speed(gi / 2), .SAT((gi % 2) == 1),
                .RSTVAL((gi == 5) ? 8'hFF : 8'(gi * 40))
            ) u_dut (
                .CLK(clk), .RST(rst8), .LD(ld8), .D(d8), .EN(en8), .DEC(dec8),
                .Q(q8[gi]), .OVF(ovf8[gi]), .ZERO(z8[gi]), .FULL(f8[gi]));
        end
    endgenerate

    int m   [6];
    bit mo  [6];

    initial begin
        int e;
        int t3q [3] = '{0, 15, 14};
        bit t3o [3] = '{1'b0, 1'b1, 1'b0};

        // Reset, then count up through the wrap.
        apply4(1, 0, 0, 0, 0);
        check("rst_q", 32'(qw), 0);
        check("rst_ovf", 32'(ovfw), 0);
        check("rst_zero", 32'(zw), 1);
        check("rst_full", 32'(fw), 0);
        check("rst_q_sat", 32'(qs), 0);
        for (int k = 1; k <= 16; k++) begin
            apply4(0, 0, 0, 1, 0);
            e = k % 16;
            check($sformatf("up_q_%0d", k), 32'(qw), 32'(e));
            check($sformatf("up_ovf_%0d", k), 32'(ovfw), 32'(k == 16));
            check($sformatf("up_full_%0d", k), 32'(fw), 32'(e == 15));
            check($sformatf("up_zero_%0d", k), 32'(zw), 32'(e == 0));
        end

        // Saturate at the top.
        apply4(0, 1, 14, 0, 0);
        check("sat_ld_q", 32'(qs), 14);
        check("sat_ld_full", 32'(fs), 0);
        for (int k = 1; k <= 4; k++) begin
            apply4(0, 0, 0, 1, 0);
            check($sformatf("sat_up_q_%0d", k), 32'(qs), 15);
            check($sformatf("sat_up_ovf_%0d", k), 32'(ovfs), 32'(k > 1));
            check($sformatf("sat_up_full_%0d", k), 32'(fs), 1);
        end
        // Saturate at the bottom, then hold clears OVF.
        apply4(0, 1, 0, 0, 0);
        apply4(0, 0, 0, 1, 1);
        check("sat_dn_q", 32'(qs), 0);
        check("sat_dn_ovf", 32'(ovfs), 1);
        check("sat_dn_zero", 32'(zs), 1);
        apply4(0, 0, 5, 0, 1);
        check("sat_hold_q", 32'(qs), 0);
        check("sat_hold_ovf", 32'(ovfs), 0);

        // Wrap downward through zero.
        apply4(0, 1, 1, 0, 0);
        check("dn_ld_q", 32'(qw), 1);
        for (int k = 0; k < 3; k++) begin
            apply4(0, 0, 0, 1, 1);
            check($sformatf("dn_q_%0d", k), 32'(qw), 32'(t3q[k]));
            check($sformatf("dn_ovf_%0d", k), 32'(ovfw), 32'(t3o[k]));
            check($sformatf("dn_zero_%0d", k), 32'(zw), 32'(t3q[k] == 0));
        end

        // Load beats an overflowing count.
        apply4(0, 1, 15, 0, 0);
        check("pri_ld15_full", 32'(fw), 1);
        apply4(0, 1, 9, 1, 0);
        check("pri_q", 32'(qw), 9);
        check("pri_ovf", 32'(ovfw), 0);

        // Reset beats load/enable and clears a pending overflow.
        apply4(0, 1, 15, 0, 0);
        apply4(1, 0, 0, 1, 0);
        check("rst_ovf_clr", 32'(ovfw), 0);
        check("rst_ovf_q", 32'(qw), 0);
        apply4(0, 1, 4, 0, 0);
        apply4(0, 0, 0, 1, 0);
        check("mid_q5", 32'(qw), 5);
        apply4(1, 1, 3, 1, 0);
        check("mid_rst_q", 32'(qw), 0);
        check("mid_rst_ovf", 32'(ovfw), 0);
        check("mid_rst_zero", 32'(zw), 1);
        apply4(0, 0, 0, 1, 0);
        check("mid_resume_q", 32'(qw), 1);

        // Idle with garbage on D/DEC leaves state untouched.
        apply4(0, 0, 4'($urandom), 0, 1);
        check("idle_q", 32'(qw), 1);
        check("idle_ovf", 32'(ovfw), 0);

        // Randomized regression on the width-8 instances.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            rst8 = (cyc == 0) || ($urandom_range(0, 99) < 2);
            ld8  = ($urandom_range(0, 99) < 5);
            en8  = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 9) == 0) dec8 = ~dec8;
            case ($urandom_range(0, 3))
                0:       d8 = 8'($urandom_range(0, 5));
                1:       d8 = 8'($urandom_range(250, 255));
                default: d8 = 8'($urandom);
            endcase
            @(posedge clk);
            #1;
            for (int k = 0; k < 6; k++) begin
                int t;
                if (rst8) begin
                    m[k] = rv(k); mo[k] = 1'b0;
                end else if (ld8) begin
                    m[k] = int'(d8); mo[k] = 1'b0;
                end else if (en8) begin
                    t     = dec8 ? m[k] - 1 : m[k] + 1;
                    mo[k] = (t < 0) || (t > 255);
                    if (!mo[k])             m[k] = t;
                    else if ((k % 2) == 0)  m[k] = (t + 256) % 256;
                end else begin
                    mo[k] = 1'b0;
                end
                check($sformatf("r%0d_q_%0d", cyc, k), 32'(q8[k]), 32'(m[k]));
                check($sformatf("r%0d_ovf_%0d", cyc, k), 32'(ovf8[k]), 32'(mo[k]));
                check($sformatf("r%0d_zero_%0d", cyc, k), 32'(z8[k]), 32'(m[k] == 0));
                check($sformatf("r%0d_full_%0d", cyc, k), 32'(f8[k]), 32'(m[k] == 255));
            end
            if ((cyc % 1000) == 999)
                $display("random cycles=%0d checks=%0d", cyc + 1, checks);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
